piso_shift_register: RTL

//   Parallel-in/serial-out shifter: reading end of the parallel D-flip-flop register path.

---
 rtl/piso_shift_register_if.sv | 23 ++
 rtl/piso_shift_register.sv | 122 ++++++++++++
 2 files changed

// File: rtl/piso_shift_register_if.sv
// Handshake and serial-output bundle for piso_shift_register.
// The master drives the parallel word; the slave is the serialiser.
interface piso_shift_register_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output d, load_valid,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  d, load_valid,
    output load_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shifter: one WIDTH-bit word per handshake, one bit per clk.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  piso_shift_register_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_e;
`else
  localparam int FRAME = WIDTH;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;
`endif
  localparam int CW = $clog2(FRAME);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic load_ready;
  logic accept;

  // The last-bit cycle doubles as an accept slot so frames can run back-to-back.
  assign load_ready = (state_q == S_IDLE) | last_q;
  assign accept     = bus.load_valid & load_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    valid_d  = valid_q;
    last_d   = last_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    if (accept) begin
      // The first bit goes straight to sout; the register keeps the remainder.
      state_d = S_SHIFT;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        sout_d  = bus.d[WIDTH-1];
        shift_d = {bus.d[WIDTH-2:0], 1'b0};
      end else begin
        sout_d  = bus.d[0];
        shift_d = {1'b0, bus.d[WIDTH-1:1]};
      end
`ifdef PISO_PARITY_EN
      parity_d = ^bus.d;
`endif
    end else if (last_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      sout_d  = 1'b0;
    end else if (state_q == S_SHIFT) begin
      cnt_d  = cnt_q + 1'b1;
      last_d = (cnt_d == CW'(FRAME - 1));
`ifdef PISO_PARITY_EN
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_PARITY;
        sout_d  = parity_q;
      end else
`endif
      if (MSB_FIRST) begin
        sout_d  = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
        sout_d  = shift_q[0];
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.sout_last  = last_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
